// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: the store address
// that the data-memory stage decodes and the transmitter FSM state encoding.
package mmio_uart_tx_pkg;

    localparam logic [31:0] MMIO_UART_ADDRESS = 32'h2000;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Small byte FIFO between the store port and the UART shifter. Pointers carry
// one extra wrap bit so full and empty are distinguishable without a counter.
module byte_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [FIFO_DEPTH_LOG2:0] level
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    logic [7:0]               mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2:0] rd_ptr;
    logic                     do_push;
    logic                     do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                      (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

    // Full/empty come from the registered pointers, so a write while full is
    // dropped even if the same cycle frees a slot.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointer update; both may advance in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: each store strobe queues one byte; queued
// bytes go out as contiguous 8N1 frames on a registered, idle-high line.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_write_enable,
    input  logic [7:0]               io_write_data,
    output logic                     fifo_full,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     tx_busy,
    output logic                     overflow_error,
    output logic                     uart_tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t state;
    uart_state_t state_next;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          tx_next;
    logic          fifo_pop;
    logic [7:0]    pop_data;
    logic          fifo_empty;
    logic          baud_done;

    byte_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (io_write_enable),
        .push_data (io_write_data),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign tx_busy   = (state != UART_IDLE) || !fifo_empty;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= UART_IDLE;
        else       state <= state_next;
    end

    // Next-state: advance on the last clock of each bit period.
    always_comb begin
        state_next = state;
        case (state)
            UART_IDLE:  if (!fifo_empty) state_next = UART_START;
            UART_START: if (baud_done) state_next = UART_DATA;
            UART_DATA:  if (baud_done && bit_idx == 3'd7) state_next = UART_STOP;
            UART_STOP:  if (baud_done) state_next = fifo_empty ? UART_IDLE : UART_START;
            default:    state_next = UART_IDLE;
        endcase
    end

    // Datapath next values: pop, line level, shifter and counters.
    always_comb begin
        fifo_pop   = 1'b0;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = uart_tx;
        case (state)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = pop_data;
                    baud_next  = '0;
                    tx_next    = 1'b0;
                end
            end
            UART_START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    tx_next    = shift[0];
                    shift_next = shift >> 1;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            UART_DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next = 1'b1;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        tx_next    = shift[0];
                        shift_next = shift >> 1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            UART_STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    // Chain straight into the next start bit with no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = pop_data;
                        tx_next    = 1'b0;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered line and datapath; reset forces the line high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            uart_tx  <= tx_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
        end
    end

    // Sticky overflow: a write that found the FIFO full was lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              overflow_error <= 1'b0;
        else if (io_write_enable && fifo_full)  overflow_error <= 1'b1;
    end

endmodule
